// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/execute front-end sequencer.
package fetch_pkg;

  localparam int DEF_PC_W   = 12;
  localparam int DEF_INST_W = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives instruction-memory address and
// loads the EX-stage instruction register with run/halt, stall and redirect.
module fetch_ctrl #(
  parameter int                 PC_W     = fetch_pkg::DEF_PC_W,
  parameter int                 INST_W   = fetch_pkg::DEF_INST_W,
  parameter logic [INST_W-1:0]  NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   pc_ex,
  output logic [INST_W-1:0] inst_ex,
  output logic              valid_ex,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  import fetch_pkg::*;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t      state;
  logic [PC_W-1:0]   pc_fetch;

  assign imem_addr = pc_fetch;

  // Redirects always take priority; in RUN they also cost one bubble slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc_fetch    <= '0;
      pc_ex       <= '0;
      inst_ex     <= NOP_INST;
      valid_ex    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc_fetch <= redirect_pc;
          end else if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (run) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (redirect_valid) begin
            pc_fetch <= redirect_pc;
            inst_ex  <= NOP_INST;
            valid_ex <= 1'b0;
            if (halt_req) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end else if (halt_req) begin
            inst_ex  <= NOP_INST;
            valid_ex <= 1'b0;
            state    <= HALT;
            halted   <= 1'b1;
          end else if (!stall) begin
            inst_ex     <= imem_rdata;
            pc_ex       <= pc_fetch;
            valid_ex    <= 1'b1;
            pc_fetch    <= pc_fetch + PC_ONE;
            fetch_count <= fetch_count + 32'd1;
          end
        end

        HALT: begin
          if (redirect_valid) begin
            pc_fetch <= redirect_pc;
          end else if (run && !halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [11:0] pc_ex;
  logic [31:0] inst_ex;
  logic        valid_ex;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction RAM contents: each word encodes its own address.
  assign imem_rdata = 32'h1000_0000 + {20'd0, imem_addr};

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_ex(pc_ex),
    .inst_ex(inst_ex), .valid_ex(valid_ex), .halted(halted),
    .fetch_count(fetch_count)
  );

  // Behavioural model: mode is "idle", "run" or "halt".
  string       m_mode;
  int unsigned m_pc, m_pcex, m_cnt;
  logic [31:0] m_inst;
  logic        m_valid;

  function automatic logic [31:0] mem_word(int unsigned a);
    return 32'h1000_0000 + (a % 4096);
  endfunction

  task automatic modelReset();
    m_mode = "idle"; m_pc = 0; m_pcex = 0; m_cnt = 0;
    m_inst = NOP; m_valid = 1'b0;
  endtask

  task automatic modelStep();
    if (m_mode == "run") begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_inst = NOP; m_valid = 1'b0;
        if (halt_req) m_mode = "halt";
      end else if (halt_req) begin
        m_inst = NOP; m_valid = 1'b0; m_mode = "halt";
      end else if (!stall) begin
        m_inst = mem_word(m_pc); m_pcex = m_pc; m_valid = 1'b1;
        m_pc = (m_pc + 1) % 4096;
        m_cnt = m_cnt + 1;
      end
    end else if (redirect_valid) begin
      m_pc = redirect_pc;
    end else if (m_mode == "idle") begin
      if (halt_req) m_mode = "halt";
      else if (run) m_mode = "run";
    end else if (run && !halt_req) begin
      m_mode = "run";
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("imem_addr", {20'd0, imem_addr}, m_pc);
    checkOutput("pc_ex", {20'd0, pc_ex}, m_pcex);
    checkOutput("inst_ex", inst_ex, m_inst);
    checkOutput("valid_ex", {31'd0, valid_ex}, {31'd0, m_valid});
    checkOutput("halted", {31'd0, halted}, {31'd0, m_mode == "halt"});
    checkOutput("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic s,
                               input logic rv, input logic [11:0] rp);
    run = r; halt_req = h; stall = s; redirect_valid = rv; redirect_pc = rp;
  endtask

  // One clock: predict, clock, then compare away from the edge.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("reset_inst", inst_ex, NOP);
    checkOutput("reset_valid", {31'd0, valid_ex}, 32'd0);
    checkOutput("reset_addr", {20'd0, imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start fetching: transition edge, then first instruction.
    applyStimulus(1, 0, 0, 0, 12'h0);
    cycle();
    cycle();
    checkOutput("first_inst", inst_ex, 32'h1000_0000);
    checkOutput("first_pcex", {20'd0, pc_ex}, 32'd0);
    cycle();
    checkOutput("second_inst", inst_ex, 32'h1000_0001);
    checkOutput("count_two", fetch_count, 32'd2);
    for (int i = 0; i < 20 && m_pc != 5; i++) cycle();

    // Stall for three cycles at pc_fetch=5.
    applyStimulus(1, 0, 1, 0, 12'h0);
    repeat (3) cycle();
    checkOutput("stall_addr", {20'd0, imem_addr}, 32'd5);
    checkOutput("stall_pcex", {20'd0, pc_ex}, 32'd4);
    checkOutput("stall_count", fetch_count, 32'd5);
    applyStimulus(1, 0, 0, 0, 12'h0);
    cycle();
    checkOutput("resume_pcex", {20'd0, pc_ex}, 32'd5);

    // Redirect with simultaneous stall.
    applyStimulus(1, 0, 1, 1, 12'h100);
    cycle();
    checkOutput("redir_bubble", inst_ex, NOP);
    checkOutput("redir_valid0", {31'd0, valid_ex}, 32'd0);
    applyStimulus(1, 0, 0, 0, 12'h0);
    cycle();
    checkOutput("redir_target", {20'd0, pc_ex}, 32'h100);
    checkOutput("redir_valid1", {31'd0, valid_ex}, 32'd1);

    // Halt at pc_fetch=20, set PC in HALT, resume.
    applyStimulus(1, 0, 0, 1, 12'h010);
    cycle();
    applyStimulus(1, 0, 0, 0, 12'h0);
    for (int i = 0; i < 20 && m_pc != 20; i++) cycle();
    applyStimulus(1, 1, 0, 0, 12'h0);
    cycle();
    checkOutput("halt_valid0", {31'd0, valid_ex}, 32'd0);
    checkOutput("halted_set", {31'd0, halted}, 32'd1);
    applyStimulus(1, 1, 0, 0, 12'h0);
    cycle();
    applyStimulus(0, 0, 0, 1, 12'h040);
    cycle();
    applyStimulus(1, 0, 0, 0, 12'h0);
    cycle();
    cycle();
    checkOutput("halt_resume_pc", {20'd0, pc_ex}, 32'h040);

    // PC wrap-around.
    applyStimulus(1, 0, 0, 1, 12'hFFE);
    cycle();
    applyStimulus(1, 0, 0, 0, 12'h0);
    cycle();
    checkOutput("wrap_ffe", {20'd0, pc_ex}, 32'hFFE);
    cycle();
    checkOutput("wrap_fff", {20'd0, pc_ex}, 32'hFFF);
    cycle();
    checkOutput("wrap_000", {20'd0, pc_ex}, 32'h000);
    cycle();
    checkOutput("wrap_001", {20'd0, pc_ex}, 32'h001);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    12'($urandom));
      cycle();
    end

    // Asynchronous reset between edges while running.
    applyStimulus(1, 0, 0, 0, 12'h0);
    repeat (4) cycle();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_inst", inst_ex, NOP);
    checkOutput("async_valid", {31'd0, valid_ex}, 32'd0);
    checkOutput("async_count", fetch_count, 32'd0);
    checkOutput("async_addr", {20'd0, imem_addr}, 32'd0);
    checkOutput("async_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 12'h0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
